// File: rtl/axi2apb_pkg.sv
// axi2apb shared types and constants.
// State encoding, timeout defaults and completion-flag layout.
package axi2apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_FINISH = 2'd3
  } xfer_state_e;

  localparam int unsigned TO_BITS_DEF = 8;
  localparam int unsigned TO_CYC_DEF  = 255;

  localparam int unsigned FLG_SLVERR  = 0;
  localparam int unsigned FLG_TIMEOUT = 1;
  localparam int unsigned FLG_W       = 2;

  function automatic logic launch_ok(
    input logic valid,
    input logic rd,
    input logic rd_full,
    input logic wr_full
  );
    return valid & ~(rd ? rd_full : wr_full);
  endfunction

endpackage

// File: rtl/axi2apb_timeout_cnt.sv
// ACCESS-phase watchdog: saturating counter with clear/enable
// and a terminal-count flag at TO_CYC-1.
module axi2apb_timeout_cnt #(
  parameter int unsigned TO_BITS = 8,
  parameter int unsigned TO_CYC  = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TO_BITS-1:0] TC_VAL = TO_BITS'(TO_CYC - 1);

  logic [TO_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/axi2apb_xfer_ctrl.sv
// APB transfer sequencer: pops a command, runs SETUP/ACCESS,
// and pulses a read or write completion with error qualifiers.
module axi2apb_xfer_ctrl
  import axi2apb_pkg::*;
#(
  parameter int unsigned TO_BITS = TO_BITS_DEF,
  parameter int unsigned TO_CYC  = TO_CYC_DEF,
  parameter bit          TO_EN   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  input  logic cmd_read,
  output logic cmd_ready,
  input  logic rsp_rd_full,
  input  logic rsp_wr_full,
  output logic psel,
  output logic penable,
  output logic pwrite,
  input  logic pready,
  input  logic pslverr,
  output logic finish_rd,
  output logic finish_wr,
  output logic slverr,
  output logic timeout,
  output logic busy
);

  xfer_state_e state_q, state_d;
  logic        pwrite_q, pwrite_d;
  logic        to_q, to_d;
  logic        psel_q, psel_d;
  logic        pen_q, pen_d;
  logic        cnt_clr, cnt_en, cnt_tc;
  logic        launch, fin;
  logic [FLG_W-1:0] flags;

  assign launch = launch_ok(cmd_valid, cmd_read, rsp_rd_full, rsp_wr_full);

  axi2apb_timeout_cnt #(
    .TO_BITS (TO_BITS),
    .TO_CYC  (TO_CYC)
  ) u_to_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    to_d     = to_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d  = ST_SETUP;
          pwrite_d = ~cmd_read;
          to_d     = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_clr = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d = ST_FINISH;
          to_d    = 1'b0;
        end else if (TO_EN && cnt_tc) begin
          state_d = ST_FINISH;
          to_d    = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_FINISH: begin
        // the queue presents the next command while the pop is acknowledged
        if (launch) begin
          state_d  = ST_SETUP;
          pwrite_d = ~cmd_read;
          to_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    psel_d = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    pen_d  = (state_d == ST_ACCESS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pwrite_q <= 1'b0;
      to_q     <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      to_q     <= to_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
    end
  end

  assign fin = (state_q == ST_FINISH);

  always_comb begin
    flags              = '0;
    flags[FLG_SLVERR]  = fin & (pslverr | to_q);
    flags[FLG_TIMEOUT] = fin & to_q;
  end

  assign cmd_ready = fin;
  assign finish_rd = fin & ~pwrite_q;
  assign finish_wr = fin & pwrite_q;
  assign slverr    = flags[FLG_SLVERR];
  assign timeout   = flags[FLG_TIMEOUT];
  assign psel      = psel_q;
  assign penable   = pen_q;
  assign pwrite    = pwrite_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi2apb_xfer_ctrl.sv
// Randomised transaction-level bench for axi2apb_xfer_ctrl.
// A command queue plus APB slave model predicts every completion.
module tb_axi2apb_xfer_ctrl;

  localparam int TOC = 4;

  logic clk, reset;
  logic cmd_valid, cmd_read, cmd_ready;
  logic rsp_rd_full, rsp_wr_full;
  logic psel, penable, pwrite;
  logic pready, pslverr;
  logic finish_rd, finish_wr, slverr, timeout, busy;

  axi2apb_xfer_ctrl #(
    .TO_BITS (8),
    .TO_CYC  (TOC),
    .TO_EN   (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_read    (cmd_read),
    .cmd_ready   (cmd_ready),
    .rsp_rd_full (rsp_rd_full),
    .rsp_wr_full (rsp_wr_full),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pready      (pready),
    .pslverr     (pslverr),
    .finish_rd   (finish_rd),
    .finish_wr   (finish_wr),
    .slverr      (slverr),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rd;
    bit err;
    int w;
  } cmd_t;

  cmd_t cq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   setup_cyc = 0;
  int   acc = 0;
  bit   exp_v = 0;
  bit   exp_setup = 0;
  bit   rand_full = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // launch rule: idle or finishing, head valid, target buffer not full
  task automatic recalc();
    cmd_valid = (cq.size() > 0);
    cmd_read  = cmd_valid ? cq[0].rd : 1'b0;
    exp_v     = cmd_ready || !psel;
    exp_setup = cmd_valid && !(cmd_read ? rsp_rd_full : rsp_wr_full);
  endtask

  task automatic step();
    bit to_exp;
    int lat;
    @(negedge clk);
    cyc++;
    if (exp_v) check("launch", int'(psel && !penable), int'(exp_setup));
    if (psel && !penable) begin
      setup_cyc = cyc;
      acc = 0;
      if (cq.size() > 0) check("pwrite_setup", pwrite, !cq[0].rd);
      check("busy_setup", busy, 1);
    end
    if (psel && penable && cq.size() > 0) begin
      check("pwrite_access", pwrite, !cq[0].rd);
      pready = (acc == cq[0].w);
      if (pready) pslverr = cq[0].err;
      acc++;
    end else begin
      pready = 1'($urandom % 2);
    end
    if (cmd_ready) begin
      if (cq.size() == 0) begin
        check("pop_empty_queue", 1, 0);
      end else begin
        to_exp = (cq[0].w >= TOC);
        lat = 2 + (to_exp ? TOC - 1 : cq[0].w);
        check("finish_rd", finish_rd, cq[0].rd);
        check("finish_wr", finish_wr, !cq[0].rd);
        check("timeout", timeout, to_exp);
        check("slverr", slverr, to_exp | cq[0].err);
        check("latency", cyc - setup_cyc, lat);
        check("psel_finish", psel, 0);
        void'(cq.pop_front());
      end
    end else if (finish_rd || finish_wr) begin
      check("finish_without_pop", 1, 0);
    end
    if (rand_full) begin
      rsp_rd_full = ($urandom % 5 == 0);
      rsp_wr_full = ($urandom % 5 == 0);
    end
    recalc();
  endtask

  task automatic run_until_empty(input int max_cyc);
    int n = 0;
    while (cq.size() > 0 && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_bound", cq.size(), 0);
  endtask

  initial begin
    cmd_t c;
    reset = 1'b1;
    cmd_valid = 0; cmd_read = 0;
    rsp_rd_full = 0; rsp_wr_full = 0;
    pready = 0; pslverr = 0;
    repeat (2) @(negedge clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_finish", int'({finish_rd, finish_wr}), 0);
    check("rst_flags", int'({slverr, timeout}), 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // read blocked by a full read buffer, decode-error style completion
    rsp_rd_full = 1;
    c.rd = 1; c.err = 1; c.w = 0;
    cq.push_back(c);
    recalc();
    repeat (5) step();
    check("blocked_psel", psel, 0);
    check("blocked_busy", busy, 0);
    rsp_rd_full = 0;
    recalc();
    run_until_empty(20);

    // write then read back to back, then a timeout on a read
    c.rd = 0; c.err = 0; c.w = 0; cq.push_back(c);
    c.rd = 1; c.err = 1; c.w = 5; cq.push_back(c);
    c.rd = 1; c.err = 0; c.w = 100; cq.push_back(c);
    c.rd = 0; c.err = 0; c.w = TOC - 1; cq.push_back(c);
    recalc();
    run_until_empty(100);

    // random traffic with random buffer back-pressure
    rand_full = 1;
    for (int i = 0; i < 60; i++) begin
      c.rd = 1'($urandom % 2);
      c.err = ($urandom % 4 == 0);
      c.w = $urandom_range(0, TOC + 2);
      cq.push_back(c);
    end
    recalc();
    run_until_empty(3000);
    rand_full = 0;
    rsp_rd_full = 0; rsp_wr_full = 0;

    // reset during ACCESS aborts; the same command reissues
    c.rd = 1; c.err = 0; c.w = 2;
    cq.push_back(c);
    recalc();
    begin
      int n = 0;
      while (!(psel && penable) && n < 20) begin
        step();
        n++;
      end
      check("reach_access", int'(psel && penable), 1);
    end
    reset = 1'b1;
    #1;
    check("abort_psel", psel, 0);
    check("abort_penable", penable, 0);
    check("abort_pop", cmd_ready, 0);
    check("abort_finish", int'({finish_rd, finish_wr}), 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    pready = 0;
    acc = 0;
    recalc();
    run_until_empty(20);

    repeat (3) step();
    check("final_busy", busy, 0);
    check("final_psel", psel, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "simulation time limit");
  end

endmodule
